itch_payload_assembler: RTL

Upstream stage of the payload decoders. Collects an ITCH byte stream, one byte per cycle, into a 512-bit left-aligned payload word. Determines message length from the type byte, then issues a single-cycle valid pulse with the frozen payload. The output drives the valid/payload inputs shared by all message-type decoders (A/D/E/X/U/F).

---
 rtl/itch_payload_assembler.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/itch_payload_assembler.sv
// ITCH byte-stream to 512-bit left-aligned payload assembler for the message-type decoders.
// Optional statistics counters are enabled with `define ITCH_ASSEMBLER_STATS_EN.
module itch_payload_assembler #(
    parameter int MAX_BYTES = 64,
    parameter int LEN_W     = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   in_sop,
    input  logic [7:0]             in_byte,
    output logic                   valid,
    output logic [MAX_BYTES*8-1:0] payload,
    output logic [LEN_W-1:0]       msg_len,
    output logic                   abort_err,
    output logic                   unknown_type
`ifdef ITCH_ASSEMBLER_STATS_EN
    ,
    output logic [31:0]            msg_count,
    output logic [15:0]            abort_count,
    output logic [15:0]            unknown_count
`endif
);

    localparam int PW = MAX_BYTES * 8;
    localparam int IW = $clog2(PW);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DROP    = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [LEN_W-1:0] cnt_r, cnt_s;
    logic [LEN_W-1:0] target_r, target_s;
    logic [PW-1:0]    buf_r, buf_s;
    logic [PW-1:0]    payload_r, payload_s;
    logic [LEN_W-1:0] msg_len_r, msg_len_s;
    logic             valid_r, valid_s;
    logic             abort_r, abort_s;
    logic             unknown_r, unknown_s;
    logic [LEN_W-1:0] sop_len_s;
    logic [IW-1:0]    wr_pos_s;

    // Total message length including the type byte; zero marks an unknown type.
    function automatic logic [LEN_W-1:0] type_len(input logic [7:0] t);
        case (t)
            8'h41:   type_len = LEN_W'(36);
            8'h46:   type_len = LEN_W'(40);
            8'h45:   type_len = LEN_W'(31);
            8'h58:   type_len = LEN_W'(23);
            8'h44:   type_len = LEN_W'(19);
            8'h55:   type_len = LEN_W'(35);
            default: type_len = LEN_W'(0);
        endcase
    endfunction

    assign sop_len_s = type_len(in_byte);
    assign wr_pos_s  = IW'(PW - 8) - IW'({cnt_r, 3'b000});

    // Next-state, buffer write and pulse generation.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        target_s  = target_r;
        buf_s     = buf_r;
        payload_s = payload_r;
        msg_len_s = msg_len_r;
        valid_s   = 1'b0;
        abort_s   = 1'b0;
        unknown_s = 1'b0;
        if (in_valid) begin
            if (in_sop) begin
                // A new start inside COLLECT truncates the message in flight.
                if (state_r == COLLECT) begin
                    abort_s = 1'b1;
                end else begin
                    abort_s = 1'b0;
                end
                if (sop_len_s != LEN_W'(0)) begin
                    buf_s    = {in_byte, {(PW - 8){1'b0}}};
                    cnt_s    = LEN_W'(1);
                    target_s = sop_len_s;
                    state_s  = COLLECT;
                end else begin
                    unknown_s = 1'b1;
                    state_s   = DROP;
                end
            end else begin
                case (state_r)
                    COLLECT: begin
                        buf_s[wr_pos_s +: 8] = in_byte;
                        cnt_s                = cnt_r + LEN_W'(1);
                        if (cnt_r == target_r - LEN_W'(1)) begin
                            payload_s = buf_s;
                            msg_len_s = target_r;
                            valid_s   = 1'b1;
                            state_s   = IDLE;
                        end else begin
                            state_s   = COLLECT;
                        end
                    end
                    default: state_s = state_r;
                endcase
            end
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= LEN_W'(0);
            target_r  <= LEN_W'(0);
            buf_r     <= {PW{1'b0}};
            payload_r <= {PW{1'b0}};
            msg_len_r <= LEN_W'(0);
            valid_r   <= 1'b0;
            abort_r   <= 1'b0;
            unknown_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            target_r  <= target_s;
            buf_r     <= buf_s;
            payload_r <= payload_s;
            msg_len_r <= msg_len_s;
            valid_r   <= valid_s;
            abort_r   <= abort_s;
            unknown_r <= unknown_s;
        end
    end

    assign valid        = valid_r;
    assign payload      = payload_r;
    assign msg_len      = msg_len_r;
    assign abort_err    = abort_r;
    assign unknown_type = unknown_r;

`ifdef ITCH_ASSEMBLER_STATS_EN
    logic [31:0] msg_cnt_r;
    logic [15:0] abort_cnt_r;
    logic [15:0] unknown_cnt_r;

    // Saturating event counters, updated on the same edge as their pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_cnt_r     <= 32'd0;
            abort_cnt_r   <= 16'd0;
            unknown_cnt_r <= 16'd0;
        end else begin
            if (valid_s && (msg_cnt_r != {32{1'b1}})) begin
                msg_cnt_r <= msg_cnt_r + 32'd1;
            end else begin
                msg_cnt_r <= msg_cnt_r;
            end
            if (abort_s && (abort_cnt_r != {16{1'b1}})) begin
                abort_cnt_r <= abort_cnt_r + 16'd1;
            end else begin
                abort_cnt_r <= abort_cnt_r;
            end
            if (unknown_s && (unknown_cnt_r != {16{1'b1}})) begin
                unknown_cnt_r <= unknown_cnt_r + 16'd1;
            end else begin
                unknown_cnt_r <= unknown_cnt_r;
            end
        end
    end

    assign msg_count     = msg_cnt_r;
    assign abort_count   = abort_cnt_r;
    assign unknown_count = unknown_cnt_r;
`endif

endmodule
